// File: rtl/memory_bus_pkg.sv
// Shared types and constants for the two-port memory bus arbiter.
package memory_bus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } arb_state_t;

    typedef logic port_idx_t;

    // Read data returned on a watchdog timeout; sliced to DATA_SIZE at use.
    localparam logic [63:0] ERROR_DATA = '1;

    // Round-robin pick: a tie goes to the port that was not granted last.
    function automatic port_idx_t rr_pick(input logic [1:0] req, input port_idx_t last);
        if (req == 2'b11) return ~last;
        return req[1];
    endfunction

endpackage

// File: rtl/memory_bus_arbiter_watchdog.sv
// Cycle watchdog for a stalled slave access; flags the TIMEOUT_CYCLES-th enabled cycle.
module bus_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            logic unused_ok;
            assign unused_ok = clock ^ reset ^ clear ^ enable;
            assign expired   = 1'b0;
        end else begin : g_on
            logic [CW-1:0] count_q, count_d;

            // count_q holds the enabled cycles already elapsed, so the limit
            // is reached during the cycle in which count_q == limit-1.
            assign expired = enable && (count_q == CW'(TIMEOUT_CYCLES - 1));

            always_comb begin
                count_d = count_q;
                if (clear)                   count_d = '0;
                else if (enable && !expired) count_d = count_q + CW'(1);
            end

            always_ff @(posedge clock or posedge reset) begin
                if (reset) count_q <= '0;
                else       count_q <= count_d;
            end
        end
    endgenerate
endmodule

// File: rtl/memory_bus_arbiter.sv
// Round-robin arbiter sharing one strobe/ready memory bus between a core (port 0)
// and a debug/loader master (port 1); one transaction in flight, registered both sides.
module memory_bus_arbiter
    import memory_bus_pkg::*;
#(
    parameter int ADDRESS_SIZE   = 16,
    parameter int DATA_SIZE      = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    m0_strobe,
    input  logic                    m0_writeEnable,
    input  logic [ADDRESS_SIZE-1:0] m0_address,
    input  logic [DATA_SIZE-1:0]    m0_dataWrite,
    output logic [DATA_SIZE-1:0]    m0_dataRead,
    output logic                    m0_ready,
    output logic                    m0_error,
    input  logic                    m1_strobe,
    input  logic                    m1_writeEnable,
    input  logic [ADDRESS_SIZE-1:0] m1_address,
    input  logic [DATA_SIZE-1:0]    m1_dataWrite,
    output logic [DATA_SIZE-1:0]    m1_dataRead,
    output logic                    m1_ready,
    output logic                    m1_error,
    output logic                    s_strobe,
    output logic                    s_writeEnable,
    output logic [ADDRESS_SIZE-1:0] s_address,
    output logic [DATA_SIZE-1:0]    s_dataWrite,
    input  logic [DATA_SIZE-1:0]    s_dataRead,
    input  logic                    s_ready,
    output logic                    grant,
    output logic                    busy
);
    arb_state_t state_q, state_d;
    port_idx_t  grant_q, grant_d, last_q, last_d, pick;

    logic                    s_strobe_q, s_strobe_d;
    logic                    s_we_q, s_we_d;
    logic [ADDRESS_SIZE-1:0] s_addr_q, s_addr_d;
    logic [DATA_SIZE-1:0]    s_wdata_q, s_wdata_d;

    logic [1:0]                rdy_q, rdy_d, err_q, err_d;
    logic [1:0][DATA_SIZE-1:0] rdata_q, rdata_d;

    logic [1:0] req;
    logic       wd_clear, wd_expired;

    assign req  = {m1_strobe, m0_strobe};
    assign pick = rr_pick(req, last_q);

    bus_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .clear   (wd_clear),
        .enable  (state_q == ACCESS),
        .expired (wd_expired)
    );

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        s_strobe_d = s_strobe_q;
        s_we_d     = s_we_q;
        s_addr_d   = s_addr_q;
        s_wdata_d  = s_wdata_q;
        rdata_d    = rdata_q;
        rdy_d      = '0;
        err_d      = '0;
        wd_clear   = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_d    = pick;
                    last_d     = pick;
                    s_strobe_d = 1'b1;
                    s_we_d     = pick ? m1_writeEnable : m0_writeEnable;
                    s_addr_d   = pick ? m1_address     : m0_address;
                    s_wdata_d  = pick ? m1_dataWrite   : m0_dataWrite;
                    wd_clear   = 1'b1;
                    state_d    = ACCESS;
                end
            end
            ACCESS: begin
                // s_ready is checked first so a completion on the timeout cycle is not an error.
                if (s_ready) begin
                    rdata_d[grant_q] = s_dataRead;
                    rdy_d[grant_q]   = 1'b1;
                    s_strobe_d       = 1'b0;
                    state_d          = RESPOND;
                end else if (wd_expired) begin
                    rdata_d[grant_q] = ERROR_DATA[DATA_SIZE-1:0];
                    rdy_d[grant_q]   = 1'b1;
                    err_d[grant_q]   = 1'b1;
                    s_strobe_d       = 1'b0;
                    state_d          = RESPOND;
                end
            end
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_q    <= 1'b0;
            last_q     <= 1'b1;
            s_strobe_q <= 1'b0;
            s_we_q     <= 1'b0;
            s_addr_q   <= '0;
            s_wdata_q  <= '0;
            rdy_q      <= '0;
            err_q      <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            s_strobe_q <= s_strobe_d;
            s_we_q     <= s_we_d;
            s_addr_q   <= s_addr_d;
            s_wdata_q  <= s_wdata_d;
            rdy_q      <= rdy_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
        end
    end

    assign s_strobe      = s_strobe_q;
    assign s_writeEnable = s_we_q;
    assign s_address     = s_addr_q;
    assign s_dataWrite   = s_wdata_q;
    assign m0_ready      = rdy_q[0];
    assign m1_ready      = rdy_q[1];
    assign m0_error      = err_q[0];
    assign m1_error      = err_q[1];
    assign m0_dataRead   = rdata_q[0];
    assign m1_dataRead   = rdata_q[1];
    assign grant         = grant_q;
    assign busy          = (state_q != IDLE);
endmodule
